// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retire-side commit trace FIFO with halt detect and CPU backpressure
//
// Captures every retired instruction from the MEM/WB stage into a show-ahead
// FIFO that a consumer drains with a valid/ready handshake.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   wb_valid, wb_pc, wb_inst,    retiring instruction from the MEM/WB register
//   wb_we, wb_waddr, wb_wdata    and its register-file write port
//   tr_valid, tr_ready           head-entry handshake
//   tr_pc, tr_inst, tr_we,       head entry fields (all zero when empty)
//   tr_waddr, tr_wdata
//   level                        current occupancy
//   cpu_stall                    registered backpressure to the CPU
//   retire_cnt                   saturating count of accepted retirements
//   halted, overflow             sticky status flags
module commit_trace_buffer #(
    parameter int          DEPTH        = 16,
    parameter int          AFULL_MARGIN = 4,
    parameter logic [31:0] HALT_INST    = 32'h0000000d
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [31:0]                wb_pc,
    input  logic [31:0]                wb_inst,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_waddr,
    input  logic [31:0]                wb_wdata,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [31:0]                tr_pc,
    output logic [31:0]                tr_inst,
    output logic                       tr_we,
    output logic [4:0]                 tr_waddr,
    output logic [31:0]                tr_wdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       cpu_stall,
    output logic [31:0]                retire_cnt,
    output logic                       halted,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int EW = 32 + 32 + 1 + 5 + 32;

    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0] STALL_LVL  = LW'(DEPTH - AFULL_MARGIN);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          halt_hit;
    logic [LW-1:0] next_level;
    logic [EW-1:0] head;

    // All-zero instruction words are pipeline bubbles and never recorded.
    assign push_req = wb_valid && (wb_inst != 32'd0) && !halted;
    assign pop      = tr_valid && tr_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok  = push_req && ((level < FULL_LVL) || pop);
    assign halt_hit = push_ok && (wb_inst == HALT_INST);

    always_comb begin
        next_level = level;
        case ({push_ok, pop})
            2'b10:   next_level = level + LW'(1);
            2'b01:   next_level = level - LW'(1);
            default: next_level = level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
            overflow   <= 1'b0;
            cpu_stall  <= 1'b0;
        end else begin
            level <= next_level;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (retire_cnt != 32'hFFFF_FFFF) begin
                    retire_cnt <= retire_cnt + 32'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (halt_hit) begin
                halted <= 1'b1;
            end
            // Once halted no further pushes arrive, so there is nothing to hold off.
            cpu_stall <= (next_level >= STALL_LVL) && !(halted || halt_hit);
        end
    end

    // Storage has no reset; entries become unreachable once level is cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {wb_pc, wb_inst, wb_we, wb_waddr, wb_wdata};
        end
    end

    assign head     = mem[rd_ptr];
    assign tr_valid = (level != '0);

    // Gate with tr_valid so an empty FIFO (including right after reset) shows zeros.
    assign tr_pc    = tr_valid ? head[EW-1 -: 32] : 32'd0;
    assign tr_inst  = tr_valid ? head[EW-33 -: 32] : 32'd0;
    assign tr_we    = tr_valid ? head[37] : 1'b0;
    assign tr_waddr = tr_valid ? head[36:32] : 5'd0;
    assign tr_wdata = tr_valid ? head[31:0] : 32'd0;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Retire-side trace capture for the dynamic pipeline CPU.
- Sits directly downstream of the MEM/WB pipeline register and register-file write port.
- Records every retired instruction (pc, instruction word, register write) into a show-ahead FIFO, which the bench or a debug port drains with a valid/ready handshake.
- Counts retirements, detects the halt instruction, and drives the CPU stall input as backpressure so no trace entries are lost.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AFULL_MARGIN, 4, free slots reserved for instructions still in flight when stall is raised; must be less than DEPTH.
- HALT_INST, 32'h0000000d, instruction word that marks program end.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  MW stage holds a real instruction this cycle.
- wb_pc  in  32  pc of the retiring instruction.
- wb_inst  in  32  MW_IR of the retiring instruction.
- wb_we  in  1  register-file write enable of the retiring instruction.
- wb_waddr  in  5  destination register.
- wb_wdata  in  32  write-back data.
- tr_valid  out  1  head entry available.
- tr_ready  in  1  consumer accepts head entry.
- tr_pc  out  32  head entry pc.
- tr_inst  out  32  head entry instruction.
- tr_we  out  1  head entry write enable.
- tr_waddr  out  5  head entry destination register.
- tr_wdata  out  32  head entry write data.
- level  out  $clog2(DEPTH+1)  current occupancy.
- cpu_stall  out  1  backpressure to the CPU stall input.
- retire_cnt  out  32  accepted retirements.
- halted  out  1  sticky; halt instruction captured.
- overflow  out  1  sticky; an entry was dropped.

Behaviour:
- Reset (async, any time, including mid-drain):
  - level, pointers, retire_cnt, halted, overflow, cpu_stall = 0; tr_valid = 0.
  - All tr_* data outputs = 0.
  - FIFO storage contents are not cleared but are unreachable.
- Capture condition: push_req = wb_valid && (wb_inst != 0) && !halted.
  - The all-zero word is a bubble and is never recorded.
- Push accept: push_req && (level < DEPTH || pop).
  - Entry is written at the rising edge.
  - Visible on tr_* (tr_valid=1) from the following cycle; latency 1 cycle.
- Pop: tr_valid && tr_ready.
  - Head advances at the edge; the next entry, if any, appears the following cycle.
  - tr_ready with tr_valid=0 has no effect.
- Simultaneous push and pop:
  - level unchanged.
  - Allowed when full; the pop frees the slot.
  - When level==1, the pushed entry becomes the head next cycle.
- Full with push_req and no pop:
  - Entry dropped; overflow set (sticky until reset).
  - level unchanged; retire_cnt not incremented.
- Empty: tr_valid=0 and tr_* data = 0.
- Pointers: log2(DEPTH) bits, natural wrap at DEPTH; level is tracked separately to distinguish full from empty.
- retire_cnt:
  - Increments by 1 on each accepted push, including the halt entry.
  - Saturates at 32'hFFFFFFFF.
- Halt:
  - An accepted push with wb_inst == HALT_INST sets halted at the same edge.
  - From the next cycle, all pushes are ignored (no overflow, no count).
  - Draining continues normally.
  - A halt entry that is dropped on full does not set halted.
- cpu_stall:
  - Registered.
  - Next value = (next_level >= DEPTH - AFULL_MARGIN) && !halted.
  - Deasserts on the edge where next_level falls below the threshold.
- Widths: all data fields stored exactly as received; no sign handling.

Test Plan:
- Reset, then push 3 instructions (pc 0x00400000/04/08, inst 0x20010005 etc.) with tr_ready=1 → each appears on tr_* exactly 1 cycle after push, in order. Final state: level=0, retire_cnt=3.
- tr_ready=0, push 12 with DEPTH=16 → cpu_stall rises on the edge level reaches 12. Then 4 more pushes → level=16, overflow=0. A 17th push → overflow=1, retire_cnt=16, level=16.
- Full FIFO, tr_ready=1 and push in the same cycle → level stays 16, no overflow. The pushed entry emerges 16 pops later; pointer wrap is verified.
- Push bubble (wb_valid=1, wb_inst=0) → no entry, retire_cnt unchanged.
- Push 0x0000000d then 2 more valid instructions → halted=1, retire_cnt counts the halt entry only once, the following 2 instructions are not recorded, and cpu_stall=0.
- Assert rst asynchronously mid-cycle with level=5 → tr_valid, level, cpu_stall, halted and overflow drop immediately without a clock edge. After release, the first push appears as the head with retire_cnt=1.
